rst_seq_gen: RTL and testbench

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_sync.sv | 23 ++
 rtl/rst_seq_gen.sv | 115 +++++++++++
 tb/tb_rst_seq_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequence generator.
package rst_seq_pkg;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DLY_W       = 8;
    localparam int unsigned DEF_SW_PULSE    = 16;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LOAD      = 2'd1,
        COUNT     = 2'd2,
        DONE      = 2'd3
    } seq_state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES rising edges.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] sync_q;

    // Shift ones in after rst_n releases; clear the whole chain on assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Sequenced per-channel reset release with per-channel software reset pulses.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DLY_W       = DEF_DLY_W,
    parameter int unsigned SW_PULSE    = DEF_SW_PULSE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*DLY_W-1:0]       dly_cfg,
    input  logic                          seq_restart,
    input  logic [NUM_CH-1:0]             sw_rst_req,
    output logic [NUM_CH-1:0]             ch_rst_n,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic [ch_idx_w(NUM_CH)-1:0]   cur_ch
);

    localparam int unsigned CH_W   = ch_idx_w(NUM_CH);
    localparam int unsigned PCNT_W = $clog2(SW_PULSE + 1);

    logic                rst_sync_n;
    seq_state_e          state;
    logic [DLY_W-1:0]    dly_cnt;
    logic [DLY_W-1:0]    dly_arr   [NUM_CH];
    logic [PCNT_W-1:0]   pulse_cnt [NUM_CH];

    rst_sync #(
        .STAGES     (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    // Split the flat delay bus into per-channel fields.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dly_arr[i] = dly_cfg[i*DLY_W +: DLY_W];
        end
    end

    // Release sequencer and software pulse handling; outputs change with the state.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= SYNC_WAIT;
            cur_ch   <= '0;
            dly_cnt  <= '0;
            ch_rst_n <= '0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pulse_cnt[i] <= '0;
            end
        end else begin
            case (state)
                SYNC_WAIT: begin
                    state    <= LOAD;
                    cur_ch   <= '0;
                    seq_busy <= 1'b1;
                end
                LOAD: begin
                    dly_cnt <= dly_arr[cur_ch];
                    state   <= COUNT;
                end
                COUNT: begin
                    if (dly_cnt == '0) begin
                        ch_rst_n[cur_ch] <= 1'b1;
                        if (cur_ch == CH_W'(NUM_CH - 1)) begin
                            state    <= DONE;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end else begin
                            cur_ch <= cur_ch + CH_W'(1);
                            state  <= LOAD;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                DONE: begin
                    if (seq_restart) begin
                        // Restart beats any software request and cancels live pulses.
                        ch_rst_n <= '0;
                        cur_ch   <= '0;
                        state    <= LOAD;
                        seq_busy <= 1'b1;
                        seq_done <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            pulse_cnt[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (sw_rst_req[i]) begin
                                pulse_cnt[i] <= PCNT_W'(SW_PULSE);
                                ch_rst_n[i]  <= 1'b0;
                            end else if (pulse_cnt[i] == PCNT_W'(1)) begin
                                pulse_cnt[i] <= '0;
                                ch_rst_n[i]  <= 1'b1;
                            end else if (pulse_cnt[i] != '0) begin
                                pulse_cnt[i] <= pulse_cnt[i] - PCNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= SYNC_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Randomized scoreboard bench for rst_seq_gen against a timestamp-based model.
module tb_rst_seq_gen;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DLY_W       = 8;
    localparam int SW_PULSE    = 16;
    localparam int CH_W        = 2;
    localparam int OW          = NUM_CH + 2 + CH_W;

    typedef logic [OW-1:0] ovec_t;
    typedef struct {
        int    cyc;
        ovec_t v;
    } evt_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_CH*DLY_W-1:0]   dly_cfg = '0;
    logic                      seq_restart = 1'b0;
    logic [NUM_CH-1:0]         sw_rst_req = '0;
    logic [NUM_CH-1:0]         ch_rst_n;
    logic                      seq_busy;
    logic                      seq_done;
    logic [CH_W-1:0]           cur_ch;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    evt_t  exp_q[$];
    ovec_t exp_prev = '0;
    ovec_t act_prev = '0;

    // Model state: phase 0 = waiting for sync, 1 = sequencing, 2 = all released
    int                m_phase = 0;
    int                m_sync  = 0;
    int                m_ch    = 0;
    int                m_load  = -1;
    int                m_rel   = -1;
    logic [NUM_CH-1:0] m_released = '0;
    int                m_low_until [NUM_CH];

    rst_seq_gen #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DLY_W       (DLY_W),
        .SW_PULSE    (SW_PULSE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dly_cfg     (dly_cfg),
        .seq_restart (seq_restart),
        .sw_rst_req  (sw_rst_req),
        .ch_rst_n    (ch_rst_n),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .cur_ch      (cur_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_dly(input logic [NUM_CH*DLY_W-1:0] cfg, input int ch);
        logic [NUM_CH*DLY_W-1:0] s;
        s = cfg >> (ch * DLY_W);
        return int'(s[DLY_W-1:0]);
    endfunction

    function automatic logic [NUM_CH*DLY_W-1:0] rand_cfg(input int max_dly);
        logic [NUM_CH*DLY_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, max_dly));
        end
        return c;
    endfunction

    // Expected outputs after edge e: a channel is high once released and outside its pulse window.
    function automatic ovec_t model_out(input int e);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = m_released[i] && !(e < m_low_until[i]);
        end
        return {v, (m_phase == 1), (m_phase == 2), CH_W'(m_ch)};
    endfunction

    task automatic note(input int e);
        ovec_t v;
        v = model_out(e);
        if (v != exp_prev) begin
            exp_q.push_back('{cyc: e, v: v});
            exp_prev = v;
        end
    endtask

    task automatic start_seq(input int e);
        m_phase = 1;
        m_ch    = 0;
        m_load  = e;
        m_rel   = -1;
    endtask

    // Reference model: release times are load edge + delay + 2, pulses cover SW_PULSE edges.
    always @(posedge clk or negedge rst_n) begin
        int e;
        if (!rst_n) begin
            m_phase    = 0;
            m_sync     = 0;
            m_ch       = 0;
            m_load     = -1;
            m_rel      = -1;
            m_released = '0;
            for (int i = 0; i < NUM_CH; i++) m_low_until[i] = 0;
            note(cyc);
        end else begin
            e = cyc + 1;
            case (m_phase)
                0: begin
                    if (m_sync < SYNC_STAGES) m_sync = m_sync + 1;
                    else start_seq(e);
                end
                1: begin
                    if (e == m_load + 1) begin
                        m_rel = e + get_dly(dly_cfg, m_ch) + 1;
                    end else if (e == m_rel) begin
                        m_released[m_ch] = 1'b1;
                        if (m_ch == NUM_CH - 1) begin
                            m_phase = 2;
                        end else begin
                            m_ch   = m_ch + 1;
                            m_load = e;
                        end
                    end
                end
                default: begin
                    if (seq_restart) begin
                        m_released = '0;
                        for (int i = 0; i < NUM_CH; i++) m_low_until[i] = 0;
                        start_seq(e);
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (sw_rst_req[i]) m_low_until[i] = e + SW_PULSE;
                        end
                    end
                end
            endcase
            note(e);
        end
    end

    // Monitor: every output change must match the next predicted event, at the same cycle.
    always @(negedge clk) begin
        ovec_t now_v;
        evt_t  ev;
        now_v = {ch_rst_n, seq_busy, seq_done, cur_ch};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            ev = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missed_event: expected {ch,busy,done,cur}=%b at cyc %0d, outputs still %b at cyc %0d",
                     ev.v, ev.cyc, now_v, cyc);
        end
        if (now_v !== act_prev) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change: got {ch,busy,done,cur}=%b at cyc %0d, expected no change",
                         now_v, cyc);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || ev.v !== now_v) begin
                    mismatched++;
                    $display("FAIL output_event: got {ch,busy,done,cur}=%b at cyc %0d, expected %b at cyc %0d",
                             now_v, cyc, ev.v, ev.cyc);
                end
            end
            act_prev = now_v;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_done(input string name, input int max_cyc, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (seq_done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: seq_done still 0 after %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    task automatic pulse_inputs(input logic rs, input logic [NUM_CH-1:0] sw);
        seq_restart = rs;
        sw_rst_req  = sw;
        @(negedge clk);
        seq_restart = 1'b0;
        sw_rst_req  = '0;
    endtask

    localparam logic [NUM_CH*DLY_W-1:0] REF_CFG = {8'd3, 8'd0, 8'd5, 8'd2};

    initial begin
        int c0;
        int t;
        bit got_ch2;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ch_rst_n", int'(ch_rst_n), 0);
        check("reset_seq_busy", int'(seq_busy), 0);
        check("reset_seq_done", int'(seq_done), 0);
        check("reset_cur_ch",   int'(cur_ch),   0);

        // Reference sequence; restart and sw requests mid-sequence must be ignored.
        dly_cfg = REF_CFG;
        rst_n   = 1'b1;
        c0      = cyc + 1;
        repeat (8) @(negedge clk);
        pulse_inputs(1'b1, '1);
        wait_done("seq_ref", 200, t);
        check("seq_ref_done_cycle", t - c0, 20);

        // Single software pulse on channel 2.
        pulse_inputs(1'b0, 4'b0100);
        repeat (20) @(negedge clk);

        // Retriggered pulse on channel 1, ten cycles in.
        pulse_inputs(1'b0, 4'b0010);
        repeat (9) @(negedge clk);
        pulse_inputs(1'b0, 4'b0010);
        repeat (30) @(negedge clk);

        // In-flight pulse on ch3, then restart together with a ch0 request; delays change mid-run.
        pulse_inputs(1'b0, 4'b1000);
        repeat (4) @(negedge clk);
        pulse_inputs(1'b1, 4'b0001);
        repeat (6) @(negedge clk);
        dly_cfg = rand_cfg(20);
        wait_done("seq_restart", 2000, t);

        // Asynchronous reset while channel 2 is counting.
        dly_cfg = REF_CFG;
        pulse_inputs(1'b1, '0);
        got_ch2 = 1'b0;
        for (int i = 0; i < 200 && !got_ch2; i++) begin
            if (cur_ch == CH_W'(2) && seq_busy) got_ch2 = 1'b1;
            else @(negedge clk);
        end
        check("reach_cur_ch_2", int'(got_ch2), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ch_rst_n", int'(ch_rst_n), 0);
        check("async_rst_seq_busy", int'(seq_busy), 0);
        check("async_rst_cur_ch",   int'(cur_ch),   0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        c0 = cyc + 1;
        wait_done("seq_after_rst", 200, t);
        check("seq_after_rst_done_cycle", t - c0, 20);

        // Randomized restarts, delay changes and software pulse bursts.
        for (int it = 0; it < 8; it++) begin
            dly_cfg = rand_cfg(12);
            pulse_inputs(1'b1, ($urandom_range(0, 1) == 1) ? NUM_CH'($urandom) : '0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                dly_cfg = rand_cfg(12);
            end
            wait_done("seq_rand", 2000, t);
            for (int k = 0; k < 40; k++) begin
                sw_rst_req = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
                @(negedge clk);
            end
            sw_rst_req = '0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (SW_PULSE + 5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
